// File: rtl/spi_slave_multich.sv
// SPI slave that exchanges one frame of CH_COUNT x CH_WIDTH bits per chip-select window.
// Frames are committed to rx_data only when exactly FRAME_BITS bits were sampled.
module spi_slave_multich #(
  parameter int CH_COUNT = 2,
  parameter int CH_WIDTH = 16,
  parameter int CPOL     = 0,
  parameter int CPHA     = 0,
  parameter int RX_RESET = 256
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         SPI_CLK,
  input  logic                         SPI_PICO,
  input  logic                         SPI_CS,
  output logic                         SPI_POCI,
  input  logic [CH_COUNT*CH_WIDTH-1:0] tx_data,
  output logic [CH_COUNT*CH_WIDTH-1:0] rx_data,
  output logic                         rx_valid,
  output logic                         frame_err,
  output logic [15:0]                  good_frames
);

  localparam int FRAME_BITS = CH_COUNT * CH_WIDTH;
  localparam int CNT_W      = $clog2(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0]      FRAME_END = CNT_W'(FRAME_BITS);
  localparam logic [CH_WIDTH-1:0]   RX_WORD   = CH_WIDTH'(RX_RESET);
  localparam logic [FRAME_BITS-1:0] RX_INIT   = {CH_COUNT{RX_WORD}};
  localparam logic POL = (CPOL != 0);
  localparam logic PHA = (CPHA != 0);

  typedef enum logic [1:0] {IDLE, ACTIVE, OVERRUN} state_t;

  state_t state, state_next;

  logic [2:0]            sclk_sync;
  logic [2:0]            cs_sync;
  logic [1:0]            pico_sync;
  logic [CNT_W-1:0]      bit_cnt;
  logic [FRAME_BITS-1:0] rx_shift;
  logic [FRAME_BITS-1:0] tx_shift;
  logic                  first_drive;

  logic sclk_rise, sclk_fall, lead_edge, trail_edge, sample_edge, drive_edge;
  logic cs_fall, cs_rise, cs_high, frame_full;
  logic do_load, do_sample, do_drive, do_commit, do_err, tx_shift_en;

  // Input synchronisers: PICO uses two flops so it lines up with the clock edge decode.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sclk_sync <= {3{POL}};
      cs_sync   <= 3'b111;
      pico_sync <= 2'b00;
    end else begin
      sclk_sync <= {sclk_sync[1:0], SPI_CLK};
      cs_sync   <= {cs_sync[1:0], SPI_CS};
      pico_sync <= {pico_sync[0], SPI_PICO};
    end
  end

  assign sclk_rise   = sclk_sync[1] & ~sclk_sync[2];
  assign sclk_fall   = ~sclk_sync[1] & sclk_sync[2];
  assign lead_edge   = POL ? sclk_fall : sclk_rise;
  assign trail_edge  = POL ? sclk_rise : sclk_fall;
  assign sample_edge = PHA ? trail_edge : lead_edge;
  assign drive_edge  = PHA ? lead_edge : trail_edge;

  assign cs_fall    = cs_sync[2] & ~cs_sync[1];
  assign cs_rise    = ~cs_sync[2] & cs_sync[1];
  assign cs_high    = cs_sync[1];
  assign frame_full = (bit_cnt == FRAME_END);

  // CS deassertion has priority over any SCLK edge detected in the same cycle.
  assign do_load     = (state == IDLE) && cs_fall;
  assign do_sample   = (state == ACTIVE) && !cs_high && sample_edge && !frame_full;
  assign do_drive    = (state != IDLE) && !cs_high && drive_edge;
  assign do_commit   = (state == ACTIVE) && cs_rise && frame_full;
  assign do_err      = cs_rise && (((state == ACTIVE) && !frame_full) || (state == OVERRUN));
  assign tx_shift_en = do_drive && !(PHA && first_drive);

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cs_fall) state_next = ACTIVE;
      ACTIVE: begin
        if (cs_high)                        state_next = IDLE;
        else if (sample_edge && frame_full) state_next = OVERRUN;
      end
      OVERRUN: if (cs_high) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Shift registers carry no reset; their contents are only observed while a frame is open.
  always_ff @(posedge clk) begin
    if (do_load)          tx_shift <= tx_data;
    else if (tx_shift_en) tx_shift <= {tx_shift[FRAME_BITS-2:0], 1'b0};
    if (do_sample)        rx_shift <= {rx_shift[FRAME_BITS-2:0], pico_sync[1]};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      bit_cnt     <= '0;
      first_drive <= 1'b0;
      rx_data     <= RX_INIT;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      good_frames <= 16'd0;
    end else begin
      rx_valid  <= do_commit;
      frame_err <= do_err;
      if (do_load) begin
        bit_cnt     <= '0;
        first_drive <= 1'b1;
      end else begin
        if (do_sample) bit_cnt     <= bit_cnt + CNT_W'(1);
        if (do_drive)  first_drive <= 1'b0;
      end
      if (do_commit) begin
        rx_data     <= rx_shift;
        good_frames <= good_frames + 16'd1;
      end
    end
  end

  assign SPI_POCI = (state != IDLE) ? tx_shift[FRAME_BITS-1] : 1'b0;

endmodule

// File: tb/tb_spi_slave_multich.sv
// Scoreboard bench: three DUT configurations (mode 0, mode 3, 4x12-bit mode 1) driven by directed frames.
module tb_spi_slave_multich;

  logic        clk = 1'b0;
  logic        rst;
  logic        sclk [3];
  logic        cs   [3];
  logic        pico [3];
  logic        poci [3];
  logic        rxv  [3];
  logic        ferr [3];
  logic [15:0] good [3];
  logic [31:0] tx0, tx1, rxd0, rxd1;
  logic [47:0] tx2, rxd2;

  always #5 clk = ~clk;

  spi_slave_multich #(.CPOL(0), .CPHA(0)) dut0 (
    .clk(clk), .rst(rst), .SPI_CLK(sclk[0]), .SPI_PICO(pico[0]), .SPI_CS(cs[0]),
    .SPI_POCI(poci[0]), .tx_data(tx0), .rx_data(rxd0), .rx_valid(rxv[0]),
    .frame_err(ferr[0]), .good_frames(good[0]));

  spi_slave_multich #(.CPOL(1), .CPHA(1)) dut1 (
    .clk(clk), .rst(rst), .SPI_CLK(sclk[1]), .SPI_PICO(pico[1]), .SPI_CS(cs[1]),
    .SPI_POCI(poci[1]), .tx_data(tx1), .rx_data(rxd1), .rx_valid(rxv[1]),
    .frame_err(ferr[1]), .good_frames(good[1]));

  spi_slave_multich #(.CH_COUNT(4), .CH_WIDTH(12), .CPOL(0), .CPHA(1)) dut2 (
    .clk(clk), .rst(rst), .SPI_CLK(sclk[2]), .SPI_PICO(pico[2]), .SPI_CS(cs[2]),
    .SPI_POCI(poci[2]), .tx_data(tx2), .rx_data(rxd2), .rx_valid(rxv[2]),
    .frame_err(ferr[2]), .good_frames(good[2]));

  typedef struct {
    int          inst;
    bit          err;
    logic [63:0] data;
    logic [15:0] good;
  } ev_t;

  ev_t         exp_q [$];
  int          checks   = 0;
  int          failures = 0;
  logic [63:0] exp_rx   [3];
  logic [15:0] exp_good [3];
  logic [63:0] miso;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic wait_half();
    repeat (8) @(negedge clk);
  endtask

  function automatic int frame_bits(input int k);
    return (k == 2) ? 48 : 32;
  endfunction

  task automatic reset_expect();
    exp_rx[0]   = 64'h0100_0100;
    exp_rx[1]   = 64'h0100_0100;
    exp_rx[2]   = 64'h0100_1001_0010_0;
    exp_rx[2]   = 64'h0000_1001_0010_0100;
    exp_good[0] = 16'd0;
    exp_good[1] = 16'd0;
    exp_good[2] = 16'd0;
  endtask

  // Queue the response a frame of nbits should produce on instance k.
  task automatic expect_frame(input int k, input int nbits, input logic [63:0] mosi);
    ev_t ev;
    ev.inst = k;
    if (nbits == frame_bits(k)) begin
      exp_rx[k]   = mosi;
      exp_good[k] = exp_good[k] + 16'd1;
      ev.err      = 1'b0;
    end else begin
      ev.err      = 1'b1;
    end
    ev.data = exp_rx[k];
    ev.good = exp_good[k];
    exp_q.push_back(ev);
  endtask

  task automatic xfer(input int k, input int nbits, input logic [63:0] mosi,
                      input int abort_at, input int chg_at, output logic [63:0] got);
    bit pol, pha;
    pol = (k == 1);
    pha = (k != 0);
    got = '0;
    sclk[k] = pol;
    cs[k]   = 1'b0;
    wait_half();
    for (int i = 0; i < nbits; i++) begin
      if (i == abort_at) begin
        rst     = 1'b0;
        cs[k]   = 1'b1;
        sclk[k] = pol;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        return;
      end
      if (i == chg_at) tx0 = ~tx0;
      if (!pha) begin
        pico[k] = mosi[nbits-1-i];
        wait_half();
        got[nbits-1-i] = poci[k];
        sclk[k] = ~pol;
        wait_half();
        sclk[k] = pol;
      end else begin
        sclk[k] = ~pol;
        pico[k] = mosi[nbits-1-i];
        wait_half();
        got[nbits-1-i] = poci[k];
        sclk[k] = pol;
        wait_half();
      end
    end
    wait_half();
    cs[k] = 1'b1;
    wait_half();
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cs[k]   = 1'b1;
      pico[k] = 1'b0;
      sclk[k] = (k == 1);
    end
    tx0 = 32'h0; tx1 = 32'h0; tx2 = 48'h0;
    reset_expect();
    fork
      begin : monitor
        logic v, e;
        logic [63:0] d;
        logic [15:0] g;
        ev_t ev;
        forever begin
          @(negedge clk);
          for (int k = 0; k < 3; k++) begin
            v = rxv[k];
            e = ferr[k];
            g = good[k];
            d = (k == 0) ? {32'h0, rxd0} : (k == 1) ? {32'h0, rxd1} : {16'h0, rxd2};
            if (v || e) begin
              if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pulse inst=%0d rx_valid=%b frame_err=%b required=none", k, v, e);
              end else begin
                ev = exp_q.pop_front();
                check("pulse_inst", k, ev.inst);
                check("pulse_both", v & e, 0);
                check("pulse_kind_err", e, ev.err);
                check("rx_data", d, ev.data);
                check("good_frames", g, ev.good);
              end
            end
          end
        end
      end
      begin : stimulus
        repeat (4) @(negedge clk);
        check("rst_rx0", rxd0, 64'h0100_0100);
        check("rst_rx2", rxd2, 64'h1001_0010_0100);
        check("rst_valid0", rxv[0], 0);
        check("rst_err0", ferr[0], 0);
        check("rst_good0", good[0], 0);
        check("rst_poci0", poci[0], 0);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        tx0 = 32'hCAFE_0101;
        expect_frame(0, 32, 64'h1234_ABCD);
        xfer(0, 32, 64'h1234_ABCD, -1, -1, miso);
        check("poci_mode0", miso, 64'hCAFE_0101);
        drain("drain_mode0");

        tx1 = 32'hCAFE_0101;
        expect_frame(1, 32, 64'h1234_ABCD);
        xfer(1, 32, 64'h1234_ABCD, -1, -1, miso);
        check("poci_mode3", miso, 64'hCAFE_0101);
        drain("drain_mode3");

        tx2 = 48'h0F0_E1D_2C3_B4A;
        expect_frame(2, 48, 64'hABC_123_456_789);
        xfer(2, 48, 64'hABC_123_456_789, -1, -1, miso);
        check("poci_4x12", miso, 64'h0F0_E1D_2C3_B4A);
        drain("drain_4x12");

        xfer(0, 32, 64'hDEAD_BEEF, 20, -1, miso);
        reset_expect();
        check("midrst_rx0", rxd0, 64'h0100_0100);
        check("midrst_good0", good[0], 0);
        check("midrst_rx1", rxd1, 64'h0100_0100);
        drain("drain_midrst");

        expect_frame(0, 31, 64'h1234_ABCD);
        xfer(0, 31, 64'h1234_ABCD, -1, -1, miso);
        check("poci_short", miso, 64'h657F_0080);
        drain("drain_short");

        expect_frame(0, 33, 64'h1_2345_6789);
        xfer(0, 33, 64'h1_2345_6789, -1, -1, miso);
        check("poci_overrun", miso, 64'h1_95FC_0202);
        drain("drain_overrun");

        tx0 = 32'h8000_0001;
        expect_frame(0, 32, 64'h0000_FFFF);
        xfer(0, 32, 64'h0000_FFFF, -1, -1, miso);
        check("poci_after_rst", miso, 64'h8000_0001);
        drain("drain_after_rst");

        tx0 = 32'h5A5A_0F0F;
        expect_frame(0, 32, 64'h1357_9BDF);
        xfer(0, 32, 64'h1357_9BDF, -1, 10, miso);
        check("poci_tx_latched", miso, 64'h5A5A_0F0F);
        drain("drain_tx_latched");

        expect_frame(0, 0, 64'h0);
        xfer(0, 0, 64'h0, -1, -1, miso);
        drain("drain_cs_only");
        check("cs_only_rx0", rxd0, 64'h1357_9BDF);
        check("cs_only_good0", good[0], 2);
        repeat (20) @(negedge clk);
      end
    join_any
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
